// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the instruction SRAM
// (active-low chip-enable + word address), waits a fixed number of cycles
// per read, and hands {pc, instruction} to decode over a valid/ready pair.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ce high for one cycle; next edge launches a read of pc
// FETCH | ce low, address stable; counting wait cycles until sample
// HOLD  | ce high, instruction presented to decode until accepted
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_ce,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] inst_addr_n;
  logic        inst_ce_n;
  logic        if_valid_n;
  logic [31:0] if_pc_n;
  logic [31:0] if_inst_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] target_aligned;

  assign target_aligned = branch_target & ~32'h3;

  // State and output registers; reset acts immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      inst_ce   <= 1'b1;
      inst_addr <= RESET_PC;
      if_valid  <= 1'b0;
      if_pc     <= 32'h0;
      if_inst   <= 32'h0;
      cnt       <= 4'h0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      inst_ce   <= inst_ce_n;
      inst_addr <= inst_addr_n;
      if_valid  <= if_valid_n;
      if_pc     <= if_pc_n;
      if_inst   <= if_inst_n;
      cnt       <= cnt_n;
    end
  end

  // Next-state and next-output logic; a redirect overrides normal progress.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    inst_ce_n   = inst_ce;
    inst_addr_n = inst_addr;
    if_valid_n  = if_valid;
    if_pc_n     = if_pc;
    if_inst_n   = if_inst;
    cnt_n       = cnt;

    if (branch_taken && state == IDLE) begin
      // IDLE already provided the ce-high gap, so launch the target directly
      // instead of stretching IDLE by another cycle.
      pc_n        = target_aligned;
      inst_addr_n = target_aligned;
      inst_ce_n   = 1'b0;
      cnt_n       = 4'h0;
      state_n     = FETCH;
    end else if (branch_taken) begin
      // Any held instruction is dropped (or was just accepted); any read in
      // flight is abandoned without capturing its data.
      pc_n       = target_aligned;
      if_valid_n = 1'b0;
      inst_ce_n  = 1'b1;
      cnt_n      = 4'h0;
      state_n    = IDLE;
    end else begin
      case (state)
        IDLE: begin
          inst_addr_n = pc;
          inst_ce_n   = 1'b0;
          cnt_n       = 4'h0;
          state_n     = FETCH;
        end
        FETCH: begin
          cnt_n = cnt + 4'h1;
          if (cnt == CNT_LAST) begin
            if_inst_n  = inst_data;
            if_pc_n    = inst_addr;
            if_valid_n = 1'b1;
            pc_n       = inst_addr + 32'h4;
            inst_ce_n  = 1'b1;
            state_n    = HOLD;
          end
        end
        HOLD: begin
          if (id_ready) begin
            if_valid_n  = 1'b0;
            inst_addr_n = pc;
            inst_ce_n   = 1'b0;
            cnt_n       = 4'h0;
            state_n     = FETCH;
          end
        end
        default: begin
          inst_ce_n  = 1'b1;
          if_valid_n = 1'b0;
          state_n    = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus a random
// run, all compared against a transaction-timing model of the fetch flow.
module tb_if_fetch_ctrl;

  localparam int          W   = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_ce;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        if_valid;
  logic        id_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;

  int errors = 0;
  int checks = 0;

  // Model: the instruction at m_pc becomes valid at edge m_due; the read for
  // it occupies the W edges before that.
  bit          m_valid;
  logic [31:0] m_pc;
  int          n;
  int          m_due;

  if_fetch_ctrl #(.RESET_PC(RPC), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .inst_ce(inst_ce), .inst_addr(inst_addr),
    .inst_data(inst_data), .if_valid(if_valid), .id_ready(id_ready),
    .if_pc(if_pc), .if_inst(if_inst), .branch_taken(branch_taken),
    .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2400_0000 + (a >> 2);
  endfunction

  assign inst_data = mem_word(inst_addr);

  function automatic logic exp_ce();
    return !(!m_valid && n >= m_due - W && n < m_due);
  endfunction

  task automatic do_reset();
    rst = 1'b1; id_ready = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0; m_valid = 0; m_pc = RPC; m_due = W + 1;
  endtask

  task automatic cycle(input logic rdy, input logic br, input logic [31:0] tgt);
    bit in_idle;
    id_ready = rdy; branch_taken = br; branch_target = tgt;
    in_idle = !m_valid && (n == m_due - W - 1);
    @(posedge clk);
    n++;
    if (br) begin
      m_valid = 0;
      m_pc    = tgt & ~32'h3;
      m_due   = in_idle ? n + W : n + W + 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
      m_pc    = m_pc + 32'h4;
      m_due   = n + W;
    end else if (!m_valid && n == m_due) begin
      m_valid = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (inst_ce !== 1'b1) begin errors++; $display("FAIL reset_ce: got %b want 1", inst_ce); end
    checks++; if (inst_addr !== RPC) begin errors++; $display("FAIL reset_addr: got %h want %h", inst_addr, RPC); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    checks++; if (if_pc !== 32'h0 || if_inst !== 32'h0) begin errors++; $display("FAIL reset_hold: got pc=%h inst=%h want 0/0", if_pc, if_inst); end
    for (int i = 1; i <= 2; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      checks++; if (inst_ce !== 1'b0 || inst_addr !== RPC || if_valid !== 1'b0) begin
        errors++; $display("FAIL first_fetch_%0d: got ce=%b addr=%h v=%b want 0/%h/0", i, inst_ce, inst_addr, if_valid, RPC);
      end
    end
    cycle(1'b0, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== mem_word(32'h0) || inst_ce !== 1'b1) begin
      errors++; $display("FAIL first_valid: got v=%b pc=%h inst=%h ce=%b want 1/0/%h/1", if_valid, if_pc, if_inst, mem_word(32'h0), inst_ce);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] seen[$];
    int ce_low = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      checks++; if (inst_ce !== exp_ce()) begin errors++; $display("FAIL stream_ce[%0d]: got %b want %b", i, inst_ce, exp_ce()); end
      if (!inst_ce) ce_low++;
      if (if_valid) begin
        seen.push_back(if_pc);
        checks++; if (if_inst !== mem_word(m_pc)) begin errors++; $display("FAIL stream_inst: got %h want %h", if_inst, mem_word(m_pc)); end
      end
    end
    checks++; if (ce_low != 6) begin errors++; $display("FAIL stream_ce_low: got %0d want 6", ce_low); end
    checks++; if (seen.size() != 3) begin errors++; $display("FAIL stream_count: got %0d want 3", seen.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (seen[i] !== 32'(4 * (i + 1))) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, seen[i], 4 * (i + 1)); end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_inst !== mem_word(32'hC) || inst_ce !== 1'b1 || inst_addr !== 32'hC) begin
        errors++; $display("FAIL backpressure[%0d]: got v=%b pc=%h inst=%h ce=%b addr=%h want 1/c/%h/1/c", i, if_valid, if_pc, if_inst, inst_ce, inst_addr, mem_word(32'hC));
      end
    end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (inst_ce !== 1'b0 || inst_addr !== 32'h10 || if_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got ce=%b addr=%h v=%b want 0/10/0", inst_ce, inst_addr, if_valid);
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b1;
    #1;
    checks++; if (inst_ce !== 1'b1 || if_valid !== 1'b0 || inst_addr !== RPC) begin
      errors++; $display("FAIL async_reset: got ce=%b v=%b addr=%h want 1/0/%h", inst_ce, if_valid, inst_addr, RPC);
    end
    do_reset();
  endtask

  task automatic test_redirect_fetch();
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (inst_ce !== 1'b0 || inst_addr !== 32'h8) begin errors++; $display("FAIL redir_pre: got ce=%b addr=%h want 0/8", inst_ce, inst_addr); end
    cycle(1'b0, 1'b1, 32'h0000_0103);
    checks++; if (inst_ce !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL redir_gap: got ce=%b v=%b want 1/0", inst_ce, if_valid); end
    cycle(1'b0, 1'b0, 32'h0);
    checks++; if (inst_ce !== 1'b0 || inst_addr !== 32'h100) begin errors++; $display("FAIL redir_addr: got ce=%b addr=%h want 0/100", inst_ce, inst_addr); end
    cycle(1'b0, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_early: got v=%b want 0", if_valid); end
    cycle(1'b0, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== mem_word(32'h100)) begin
      errors++; $display("FAIL redir_target: got v=%b pc=%h inst=%h want 1/100/%h", if_valid, if_pc, if_inst, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_handshake();
    logic [31:0] seen[$];
    int acc4 = 0;
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin errors++; $display("FAIL hs_pre: got v=%b pc=%h want 1/4", if_valid, if_pc); end
    if (if_valid && if_pc == 32'h4) acc4++;
    cycle(1'b1, 1'b1, 32'h0000_0040);
    checks++; if (if_valid !== 1'b0 || inst_ce !== 1'b1) begin errors++; $display("FAIL hs_redir: got v=%b ce=%b want 0/1", if_valid, inst_ce); end
    for (int i = 0; i < 8; i++) begin
      if (if_valid && if_pc == 32'h4) acc4++;
      cycle(1'b1, 1'b0, 32'h0);
      if (if_valid) seen.push_back(if_pc);
    end
    checks++; if (acc4 != 1) begin errors++; $display("FAIL hs_consumed: got %0d want 1", acc4); end
    checks++; if (seen.size() < 1) begin errors++; $display("FAIL hs_next: got none want 00000040"); end
    else if (seen[0] !== 32'h40) begin errors++; $display("FAIL hs_next: got %h want 00000040", seen[0]); end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_inst !== mem_word(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_top: got v=%b pc=%h inst=%h want 1/fffffffc/%h", if_valid, if_pc, if_inst, mem_word(32'hFFFF_FFFC));
    end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (inst_ce !== 1'b0 || inst_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got ce=%b addr=%h want 0/0", inst_ce, inst_addr); end
    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL wrap_next: got v=%b pc=%h want 1/0", if_valid, if_pc); end
  endtask

  task automatic test_random();
    logic        rdy, br;
    logic [31:0] tgt;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 2) != 0);
      br  = ($urandom_range(0, 7) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(rdy, br, tgt);
      checks++; if (if_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, if_valid, m_valid); end
      checks++; if (inst_ce !== exp_ce()) begin errors++; $display("FAIL rnd_ce[%0d]: got %b want %b", i, inst_ce, exp_ce()); end
      if (!exp_ce()) begin
        checks++; if (inst_addr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, inst_addr, m_pc); end
      end
      if (m_valid) begin
        checks++; if (if_pc !== m_pc || if_inst !== mem_word(m_pc)) begin
          errors++; $display("FAIL rnd_data[%0d]: got pc=%h inst=%h want %h/%h", i, if_pc, if_inst, m_pc, mem_word(m_pc));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_async_reset();
    test_redirect_fetch();
    test_redirect_handshake();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
